// File: rtl/serv_rf_ram_ctrl_pkg.sv
// Shared constants and types for the SERV register-file RAM controller.
// Holds the RF geometry, CSR register numbers and the read FSM encoding.
package serv_rf_ram_ctrl_pkg;

  localparam int RF_REGS = 36;
  localparam int RF_AW   = 6;

  localparam logic [RF_AW-1:0] CSR_MSCRATCH = 6'd32;
  localparam logic [RF_AW-1:0] CSR_MTVEC    = 6'd33;
  localparam logic [RF_AW-1:0] CSR_MEPC     = 6'd34;
  localparam logic [RF_AW-1:0] CSR_MTVAL    = 6'd35;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_RDY,
    ST_RUN
  } rd_state_e;

  // RAM address = register number plus word index within the 32-bit register
  function automatic int ram_aw(input int width);
    return RF_AW + $clog2(32 / width);
  endfunction

endpackage

// File: rtl/serv_rf_ram_ctrl_if.sv
// Single-read/single-write synchronous RAM port as driven by the RF controller.
// The controller uses the master side; the RAM macro (or its model) the slave side.
interface serv_rf_ram_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int AW    = 9
);
  logic [AW-1:0]    raddr;
  logic             ren;
  logic [WIDTH-1:0] rdata;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             wen;

  modport master (output raddr, ren, waddr, wdata, wen, input rdata);
  modport slave  (input raddr, ren, waddr, wdata, wen, output rdata);
endinterface

// File: rtl/serv_rf_ser2par.sv
// Packs one serial write port into WIDTH-bit RAM words and holds the finished
// word, its RAM address and enable until the top-level write mux consumes it.
module serv_rf_ser2par
  import serv_rf_ram_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WW    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cnt_en,
  input  logic                   last,
  input  logic                   wdata,
  input  logic                   wen,
  input  logic [RF_AW-1:0]       wreg,
  input  logic [WW-1:0]          word,
  output logic [WIDTH-1:0]       wb_data,
  output logic [RF_AW+WW-1:0]    wb_addr,
  output logic                   wb_en
);

  logic [WIDTH-2:0] ws;

  // The last bit of a word is taken straight from wdata, so ws only needs WIDTH-1 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws      <= '0;
      wb_data <= '0;
      wb_addr <= '0;
      wb_en   <= 1'b0;
    end else begin
      if (cnt_en) ws <= {wdata, ws[WIDTH-2:1]};
      if (last) begin
        wb_data <= {wdata, ws};
        wb_addr <= {wreg, word};
        wb_en   <= wen;
      end
    end
  end

endmodule

// File: rtl/serv_rf_ram_ctrl.sv
// Makes a 1R1W synchronous RAM look like SERV's 2R2W bit-serial register file:
// operand prefetch with a ready handshake, and two serial write ports sharing one RAM write port.
module serv_rf_ram_ctrl
  import serv_rf_ram_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rreq,
  output logic             o_ready,
  input  logic             i_cnt_en,
  input  logic [RF_AW-1:0] i_rreg0,
  input  logic [RF_AW-1:0] i_rreg1,
  output logic             o_rdata0,
  output logic             o_rdata1,
  input  logic [RF_AW-1:0] i_wreg0,
  input  logic [RF_AW-1:0] i_wreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic             i_wdata0,
  input  logic             i_wdata1,
  serv_rf_ram_ctrl_if.master ram
);

  localparam int AW = ram_aw(WIDTH);
  localparam int PW = $clog2(WIDTH);
  localparam int WW = 5 - PW;
  localparam logic [PW-1:0] P_LAST = PW'(WIDTH - 1);
  localparam logic [WW-1:0] W_LAST = '1;

  rd_state_e        state, state_nxt;
  logic [4:0]       cnt;
  logic [PW-1:0]    phase;
  logic [WW-1:0]    word, word_nxt;
  logic [RF_AW-1:0] rreg0_q, rreg1_q;
  logic [WIDTH-1:0] sr0, sr1, pb0, pb1;
  logic             pf0, pf1, pf0_vld_p1, pf1_vld_p1;
  logic             ren;
  logic [AW-1:0]    raddr;
  logic             wr_last, wr_vld_p1, wr_vld_p2;
  logic [WIDTH-1:0] wb0_data, wb1_data;
  logic [AW-1:0]    wb0_addr, wb1_addr;
  logic             wb0_en, wb1_en;

  assign phase    = cnt[PW-1:0];
  assign word     = cnt[4:PW];
  assign word_nxt = word + WW'(1);
  assign wr_last  = i_cnt_en && (phase == P_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt <= '0;
    else if (i_cnt_en) cnt <= cnt + 5'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  end

  // Prefetch reads word n+1 of reg0 at phase 0 and of reg1 at phase 1 during word n
  always_comb begin
    state_nxt = state;
    ren       = 1'b0;
    raddr     = '0;
    o_ready   = 1'b0;
    pf0       = 1'b0;
    pf1       = 1'b0;
    unique case (state)
      ST_IDLE: if (i_rreq && cnt == '0) state_nxt = ST_RD0;
      ST_RD0: begin
        ren       = 1'b1;
        raddr     = {i_rreg0, {WW{1'b0}}};
        state_nxt = ST_RD1;
      end
      ST_RD1: begin
        ren       = 1'b1;
        raddr     = {rreg1_q, {WW{1'b0}}};
        state_nxt = ST_RDY;
      end
      ST_RDY: begin
        o_ready   = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_cnt_en) begin
          if (word != W_LAST && phase == '0) begin
            pf0   = 1'b1;
            ren   = 1'b1;
            raddr = {rreg0_q, word_nxt};
          end
          if (word != W_LAST && phase == PW'(1)) begin
            pf1   = 1'b1;
            ren   = 1'b1;
            raddr = {rreg1_q, word_nxt};
          end
          if (cnt == 5'd31) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // p1: RAM data returns one cycle after the read; route it to sr or pb
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rreg0_q    <= '0;
      rreg1_q    <= '0;
      sr0        <= '0;
      sr1        <= '0;
      pb0        <= '0;
      pb1        <= '0;
      pf0_vld_p1 <= 1'b0;
      pf1_vld_p1 <= 1'b0;
    end else begin
      pf0_vld_p1 <= pf0;
      pf1_vld_p1 <= pf1;
      if (state == ST_RD0) begin
        rreg0_q <= i_rreg0;
        rreg1_q <= i_rreg1;
      end
      if (pf0_vld_p1) pb0 <= ram.rdata;
      if (pf1_vld_p1) pb1 <= ram.rdata;
      if (state == ST_RD1) sr0 <= ram.rdata;
      else if (state == ST_RUN && i_cnt_en) sr0 <= (phase == P_LAST) ? pb0 : (sr0 >> 1);
      if (state == ST_RDY) sr1 <= ram.rdata;
      else if (state == ST_RUN && i_cnt_en) sr1 <= (phase == P_LAST) ? pb1 : (sr1 >> 1);
    end
  end

  assign o_rdata0  = sr0[0];
  assign o_rdata1  = sr1[0];
  assign ram.ren   = ren;
  assign ram.raddr = raddr;

  serv_rf_ser2par #(.WIDTH(WIDTH), .WW(WW)) u_wp0 (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .cnt_en  (i_cnt_en),
    .last    (wr_last),
    .wdata   (i_wdata0),
    .wen     (i_wen0),
    .wreg    (i_wreg0),
    .word    (word),
    .wb_data (wb0_data),
    .wb_addr (wb0_addr),
    .wb_en   (wb0_en)
  );

  serv_rf_ser2par #(.WIDTH(WIDTH), .WW(WW)) u_wp1 (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .cnt_en  (i_cnt_en),
    .last    (wr_last),
    .wdata   (i_wdata1),
    .wen     (i_wen1),
    .wreg    (i_wreg1),
    .word    (word),
    .wb_data (wb1_data),
    .wb_addr (wb1_addr),
    .wb_en   (wb1_en)
  );

  // p1/p2: port0 writes the cycle after a word completes, port1 the cycle after that
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_vld_p1 <= 1'b0;
      wr_vld_p2 <= 1'b0;
    end else begin
      wr_vld_p1 <= wr_last;
      wr_vld_p2 <= wr_vld_p1;
    end
  end

  always_comb begin
    ram.wen   = 1'b0;
    ram.waddr = '0;
    ram.wdata = '0;
    if (wr_vld_p1) begin
      ram.wen   = wb0_en;
      ram.waddr = wb0_addr;
      ram.wdata = wb0_data;
    end else if (wr_vld_p2) begin
      ram.wen   = wb1_en;
      ram.waddr = wb1_addr;
      ram.wdata = wb1_data;
    end
  end

endmodule

// File: tb/tb_serv_rf_ram_ctrl.sv
// Scoreboard bench for serv_rf_ram_ctrl (WIDTH=4) against a behavioural 1R1W RAM.
module tb_serv_rf_ram_ctrl;
  import serv_rf_ram_ctrl_pkg::*;

  localparam int WIDTH = 4;
  localparam int AW    = 9;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic [31:0]      cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  logic i_rreq, o_ready, i_cnt_en, o_rdata0, o_rdata1;
  logic [5:0] i_rreg0, i_rreg1, i_wreg0, i_wreg1;
  logic i_wen0, i_wen1, i_wdata0, i_wdata1;

  serv_rf_ram_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) ram ();

  serv_rf_ram_ctrl #(.WIDTH(WIDTH)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_rreq   (i_rreq),
    .o_ready  (o_ready),
    .i_cnt_en (i_cnt_en),
    .i_rreg0  (i_rreg0),
    .i_rreg1  (i_rreg1),
    .o_rdata0 (o_rdata0),
    .o_rdata1 (o_rdata1),
    .i_wreg0  (i_wreg0),
    .i_wreg1  (i_wreg1),
    .i_wen0   (i_wen0),
    .i_wen1   (i_wen1),
    .i_wdata0 (i_wdata0),
    .i_wdata1 (i_wdata1),
    .ram      (ram)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM with 1-cycle read latency and a preload port
  logic [WIDTH-1:0] mem [2**AW];
  logic             pl_en;
  logic [AW-1:0]    pl_addr;
  logic [WIDTH-1:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram.wen) mem[ram.waddr] <= ram.wdata;
    if (ram.ren) ram.rdata <= mem[ram.raddr];
  end

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] ren_q [$];
  wr_t           wr_q  [$];
  logic [1:0]    bit_q [$];
  int            rdy_q [$];

  logic        rd_active;
  int          tb_cnt;
  logic [5:0]  cur_r0, cur_r1, cur_wreg0, cur_wreg1;
  logic [31:0] cur_rv0, cur_rv1, cur_wv0, cur_wv1;
  logic        cur_wen0, cur_wen1;
  logic [31:0] x5_val = 32'hDEADBEEF;
  logic [31:0] x7_val = 32'h12345678;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h want no event (cycle %0d)", nm, act, cyc);
  endtask

  // Monitors: pop the next expectation whenever the DUT presents an event
  logic [AW-1:0] m_ea;
  wr_t           m_ew;
  logic [1:0]    m_eb;
  int            m_er;

  always @(negedge clk) begin
    if (ram.ren) begin
      if (ren_q.size() == 0) miss("ren_unexpected", 64'(ram.raddr));
      else begin
        m_ea = ren_q.pop_front();
        chk("ren_addr", 64'(ram.raddr), 64'(m_ea));
      end
    end
  end

  always @(negedge clk) begin
    if (ram.wen) begin
      if (wr_q.size() == 0) miss("wen_unexpected", 64'(ram.waddr));
      else begin
        m_ew = wr_q.pop_front();
        chk("wr_addr", 64'(ram.waddr), 64'(m_ew.addr));
        chk("wr_data", 64'(ram.wdata), 64'(m_ew.data));
        chk("wr_cycle", 64'(cyc), 64'(m_ew.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (rd_active && i_cnt_en) begin
      if (bit_q.size() == 0) miss("rdata_unexpected", 64'({o_rdata1, o_rdata0}));
      else begin
        m_eb = bit_q.pop_front();
        chk("rdata_bits", 64'({o_rdata1, o_rdata0}), 64'(m_eb));
      end
    end
  end

  always @(negedge clk) begin
    if (o_ready) begin
      if (rdy_q.size() == 0) miss("ready_unexpected", 64'(cyc));
      else begin
        m_er = rdy_q.pop_front();
        chk("ready_cycle", 64'(cyc), 64'(m_er));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_cnt_en  = 1'b0;
      i_rreq    = 1'b0;
      rd_active = 1'b0;
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    @(posedge clk); #1;
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
  endtask

  // One serial bit: drive it and push every response it implies
  task automatic pulse(input bit rd);
    wr_t e;
    int  k;
    @(posedge clk); #1;
    i_rreq    = 1'b0;
    i_cnt_en  = 1'b1;
    rd_active = rd;
    i_wreg0   = cur_wreg0;
    i_wreg1   = cur_wreg1;
    i_wen0    = cur_wen0;
    i_wen1    = cur_wen1;
    i_wdata0  = cur_wv0[tb_cnt];
    i_wdata1  = cur_wv1[tb_cnt];
    k = tb_cnt / 4;
    if (rd) begin
      bit_q.push_back({cur_rv1[tb_cnt], cur_rv0[tb_cnt]});
      if (k < 7 && tb_cnt % 4 == 0) ren_q.push_back({cur_r0, 3'(k + 1)});
      if (k < 7 && tb_cnt % 4 == 1) ren_q.push_back({cur_r1, 3'(k + 1)});
    end
    if (tb_cnt % 4 == 3) begin
      if (cur_wen0) begin
        e.addr = {cur_wreg0, 3'(k)};
        e.data = cur_wv0[4*k +: 4];
        e.cyc  = 32'(cyc + 1);
        wr_q.push_back(e);
      end
      if (cur_wen1) begin
        e.addr = {cur_wreg1, 3'(k)};
        e.data = cur_wv1[4*k +: 4];
        e.cyc  = 32'(cyc + 2);
        wr_q.push_back(e);
      end
    end
    tb_cnt = (tb_cnt + 1) % 32;
  endtask

  task automatic do_read(input logic [5:0] r0, input logic [5:0] r1,
                         input logic [31:0] v0, input logic [31:0] v1,
                         input bit stall, input int npulse);
    logic [1:0] hold;
    @(posedge clk); #1;
    cur_r0  = r0;
    cur_r1  = r1;
    cur_rv0 = v0;
    cur_rv1 = v1;
    i_rreq  = 1'b1;
    i_rreg0 = r0;
    i_rreg1 = r1;
    ren_q.push_back({r0, 3'd0});
    ren_q.push_back({r1, 3'd0});
    rdy_q.push_back(cyc + 3);
    @(posedge clk); #1;
    i_rreq = 1'b0;
    @(posedge clk); #1;
    i_rreg0 = '0;
    i_rreg1 = '0;
    @(posedge clk); #1;
    for (int c = 0; c < npulse; c++) begin
      if (stall && c == 6) begin
        hold = {v1[6], v0[6]};
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          i_cnt_en  = 1'b0;
          rd_active = 1'b0;
          @(negedge clk);
          chk("stall_hold", 64'({o_rdata1, o_rdata0}), 64'(hold));
        end
      end
      pulse(1'b1);
    end
    if (npulse == 32) idle(3);
  endtask

  task automatic do_write(input logic [5:0] w0, input bit e0, input logic [31:0] v0,
                          input logic [5:0] w1, input bit e1, input logic [31:0] v1);
    cur_wreg0 = w0;
    cur_wen0  = e0;
    cur_wv0   = v0;
    cur_wreg1 = w1;
    cur_wen1  = e1;
    cur_wv1   = v1;
    for (int c = 0; c < 32; c++) begin
      pulse(1'b0);
      // a read request with cnt != 0 must be ignored
      if (c == 10) i_rreq = 1'b1;
    end
    idle(4);
    cur_wen0 = 1'b0;
    cur_wen1 = 1'b0;
    i_wen0   = 1'b0;
    i_wen1   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_rreq = 1'b0; i_cnt_en = 1'b0; rd_active = 1'b0;
    i_rreg0 = '0; i_rreg1 = '0; i_wreg0 = '0; i_wreg1 = '0;
    i_wen0 = 1'b0; i_wen1 = 1'b0; i_wdata0 = 1'b0; i_wdata1 = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0; tb_cnt = 0;
    cur_r0 = '0; cur_r1 = '0; cur_rv0 = '0; cur_rv1 = '0;
    cur_wreg0 = '0; cur_wreg1 = '0; cur_wv0 = '0; cur_wv1 = '0;
    cur_wen0 = 1'b0; cur_wen1 = 1'b0;

    for (int k = 0; k < 8; k++) begin
      preload({6'd5, 3'(k)}, x5_val[4*k +: 4]);
      preload({6'd7, 3'(k)}, x7_val[4*k +: 4]);
      preload({6'd12, 3'(k)}, 4'h0);
    end
    @(posedge clk); #1;
    pl_en = 1'b0;

    // Reset state
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_rdata", 64'({o_rdata1, o_rdata0}), 64'd0);
    chk("rst_ren", 64'({ram.ren, ram.raddr}), 64'd0);
    chk("rst_wen", 64'({ram.wen, ram.waddr, ram.wdata}), 64'd0);
    idle(3);

    // Read stream x5/x7
    do_read(6'd5, 6'd7, x5_val, x7_val, 1'b0, 32);

    // Single-port write to x10
    do_write(6'd10, 1'b1, 32'hA5A5A5A5, 6'd0, 1'b0, 32'h0);

    // Dual write to MEPC, port1 wins, then read it back on both operands
    do_write(CSR_MEPC, 1'b1, 32'h0, CSR_MEPC, 1'b1, 32'hFFFFFFFF);
    do_read(CSR_MEPC, CSR_MEPC, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32);
    do_read(6'd10, 6'd5, 32'hA5A5A5A5, x5_val, 1'b0, 32);

    // Stall at cnt=6
    do_read(6'd5, 6'd7, x5_val, x7_val, 1'b1, 32);

    // Reset mid-RUN at cnt=13 with a write in flight
    cur_wreg0 = 6'd12;
    cur_wen0  = 1'b1;
    cur_wv0   = 32'h77777777;
    do_read(6'd5, 6'd7, x5_val, x7_val, 1'b0, 13);
    @(posedge clk); #1;
    i_cnt_en  = 1'b1;
    rd_active = 1'b0;
    i_wdata0  = cur_wv0[13];
    #1;
    chk("ren_before_reset", 64'({ram.ren, ram.raddr}), 64'({1'b1, 6'd7, 3'd4}));
    rst_n = 1'b0;
    #1;
    chk("async_rst_ren", 64'(ram.ren), 64'd0);
    chk("async_rst_wen", 64'(ram.wen), 64'd0);
    chk("async_rst_rdata", 64'({o_rdata1, o_rdata0}), 64'd0);
    chk("async_rst_ready", 64'(o_ready), 64'd0);
    cur_wen0 = 1'b0;
    i_wen0   = 1'b0;
    tb_cnt   = 0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    chk("word2_written", 64'(mem[{6'd12, 3'd2}]), 64'h7);
    chk("pending_word_dropped", 64'(mem[{6'd12, 3'd3}]), 64'h0);
    do_read(6'd5, 6'd7, x5_val, x7_val, 1'b0, 32);

    idle(4);
    chk("ren_q_empty", 64'(ren_q.size()), 64'd0);
    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
    chk("bit_q_empty", 64'(bit_q.size()), 64'd0);
    chk("rdy_q_empty", 64'(rdy_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serv_rf_ram_ctrl.md
# serv_rf_ram_ctrl

Sequences a synchronous single-read/single-write RAM so it behaves as the two-read/two-write bit-serial register file seen by the SERV core. Registers x0–x31 and the four CSRs (MSCRATCH, MTVEC, MEPC, MTVAL) are stored as WIDTH-bit RAM words. The block sits between the core's RF interface and the RAM macro. It handles:
- operand prefetch and the read-ready handshake;
- serial-to-parallel write packing;
- time-multiplexing of the two write ports onto one RAM write port.

## Interface
- WIDTH, 4: RAM data width; legal 4, 8, 16.
- AW, derived 6+log2(32/WIDTH): RAM address width.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rreq  in  1  operand read request.
- o_ready  out  1  operands prefetched, streaming may start.
- i_cnt_en  in  1  serial bit strobe.
- i_rreg0, i_rreg1  in  6  read register addresses (CSRs at 32–35).
- o_rdata0, o_rdata1  out  1  serial read data, LSB first.
- i_wreg0, i_wreg1  in  6  write register addresses.
- i_wen0, i_wen1  in  1  write enables.
- i_wdata0, i_wdata1  in  1  serial write data, LSB first.
- o_raddr  out  AW  RAM read address.
- o_ren  out  1  RAM read strobe.
- i_rdata  in  WIDTH  RAM read data, valid the cycle after o_ren.
- o_waddr  out  AW  RAM write address.
- o_wdata  out  WIDTH  RAM write data.
- o_wen  out  1  RAM write strobe.

## Operation
- **Addressing.** RAM address = {reg[5:0], word}, where word = cnt[4:log2 WIDTH].
- **Counters.** cnt[4:0] advances on every i_cnt_en in every state and wraps 31→0. Phase p = cnt mod WIDTH.
- **Read FSM states:** IDLE, RD0, RD1, RDY, RUN.
- **IDLE → RD0:** on i_rreq when cnt==0. i_rreq is ignored in any other state or when cnt≠0.
- **RD0:** latch i_rreg0/i_rreg1. Issue a read of word 0 of reg0.
- **RD1:** issue a read of word 0 of reg1; capture reg0 data into shift register sr0.
- **RDY:** capture reg1 data into sr1. o_ready=1 for this cycle only. Go to RUN.
- **RUN:**
  - On each i_cnt_en: sr0 and sr1 shift right; o_rdataN = srN[0].
  - Prefetch of word n+1 during word n: at p==0 with i_cnt_en, issue a read of reg0; at p==1 with i_cnt_en, issue a read of reg1.
  - Returned data goes into buffers pb0 and pb1 the following cycle.
  - At p==WIDTH-1 with i_cnt_en, sr0/sr1 load from pb0/pb1.
  - No prefetch is issued during the last word.
  - RUN → IDLE on i_cnt_en with cnt==31.
- **Stalls.** i_cnt_en low freezes shifting, counting and read issue. Capture of already-returned data still occurs.
- **Write path** (independent of FSM state):
  - On i_cnt_en, ws0/ws1 shift in i_wdata0/i_wdata1.
  - At p==WIDTH-1 with i_cnt_en, the completed word (shift register plus current bit), i_wregN, word and i_wenN are latched into wb0/wb1.
  - Next cycle: o_wen=wen0 with port0's address and data.
  - Cycle after that: o_wen=wen1 with port1's address and data.
- **Same-address writes.** If both ports target the same register, port1 is written second and wins.
- **x0 writes** are not filtered here; filtering is upstream.

## Timing
- **Reset values:** all outputs 0; FSM in IDLE; cnt=0; all buffers 0; pending writes discarded.
- **Reset assertion is asynchronous.** o_wen and o_ren drop immediately, including mid-RUN.
- **o_ready** is high exactly 3 cycles after the cycle i_rreq is sampled (cycle 0), i.e. in cycle 3.
- **First read data:** the first i_cnt_en may come in cycle 4. Bit 0 is valid on o_rdata from cycle 4.
- **Read latency:** RAM read latency is 1 cycle. A prefetched word must be in pbN before p==WIDTH-1; this holds for WIDTH≥4.
- **Write latency:** the RAM write for a word occurs 1 cycle (port0) and 2 cycles (port1) after its last bit.
- **Port exclusivity:** at most one o_ren and one o_wen per cycle. Port0 and port1 writes never overlap the next word's writes, since WIDTH≥4.
- **After the final word:** writes of word 32/WIDTH-1 complete after RUN exits, even if the FSM is back in IDLE.

## Structure
- RF_REGS=36 and the RF register-address width of 6 go in serv_params.vh, alongside the existing CSR address constants.
- One sub-module, serv_rf_ser2par: serial-to-WIDTH packer plus its write buffer. Instantiated twice, once per write port.
- Read FSM, prefetch buffers and write-port mux live in the top module.

## Test plan
All scenarios use WIDTH=4.
- **Reset:** release reset → all outputs 0, no o_ren/o_wen until i_rreq or the first completed word.
- **Read stream:**
  - Stimulus: preload x5=0xDEADBEEF, x7=0x12345678; i_rreq with rreg0=5, rreg1=7; then 32 consecutive i_cnt_en.
  - Response: o_ready in cycle 3; serial outputs match both values LSB first.
  - Response: o_ren pulses at addresses {5,k} and {7,k} for k=1..7 only.
- **Single-port write:**
  - Stimulus: wreg0=10, wen0=1, serial 0xA5A5A5A5.
  - Response: 8 writes, each 1 cycle after every p==3, to {10,k} with data 5,A,5,A,…
  - Response: the final write lands after cnt wraps.
- **Dual write, same register:** wreg0=wreg1=34, port0=0x0, port1=0xFFFFFFFF → each word written 0 then F; MEPC reads back 0xFFFFFFFF.
- **Stall:** drop i_cnt_en for 5 cycles at cnt=6 during a read → o_rdata holds, no extra o_ren, remaining stream correct.
- **Reset mid-operation:**
  - Stimulus: assert i_rst_n low at cnt=13 in RUN with wen0=1.
  - Response: outputs 0 immediately; the pending word is not written.
  - Response: a following i_rreq at cnt==0 returns correct data.
